// File: rtl/redmule_tile_evt_ctrl.sv
// Event/interrupt controller for a RedMulE tile: latches accelerator events, drives
// masked interrupt lines, wakes a sleeping core and handshakes fence.i flushes.
//
// state   | meaning
// IDLE    | core awake, no wake-up pending
// SLEEP   | core in wait-for-event, counting sleep cycles
// WAKE    | wake-up issued, waiting for core to leave sleep
// F_IDLE  | no flush in progress
// F_WAIT  | flush requested, waiting for accelerator to go idle
// F_ACK   | flush acknowledged, waiting for request release
module redmule_tile_evt_ctrl #(
    parameter int N_CORE       = 1,
    parameter int N_IRQ        = 32,
    parameter int EVT_IRQ_BASE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CORE-1:0][1:0]   evt,
    input  logic                     busy,
    input  logic                     core_sleep,
    input  logic                     fencei_flush_req,
    output logic                     fencei_flush_ack,
    input  logic                     cfg_we,
    input  logic [2*N_CORE-1:0]      cfg_mask,
    input  logic                     clr_valid,
    input  logic [2*N_CORE-1:0]      clr_mask,
    output logic [N_IRQ-1:0]         irq,
    output logic                     wu_wfe,
    output logic [2*N_CORE-1:0]      pending,
    output logic [31:0]              sleep_cycles
);

    localparam int N_EVT = 2 * N_CORE;

    if (EVT_IRQ_BASE + N_EVT > N_IRQ) begin : g_cfg_check
        $error("redmule_tile_evt_ctrl: event irq range exceeds N_IRQ");
    end

    typedef enum logic [1:0] {IDLE, SLEEP, WAKE} wake_state_t;
    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_ACK} flush_state_t;

    logic [N_EVT-1:0] evt_flat;
    logic [N_EVT-1:0] pending_q, pending_n;
    logic [N_EVT-1:0] mask_q;
    logic [N_EVT-1:0] clr_bits;
    logic [N_IRQ-1:0] irq_q, irq_n;
    logic             evt_hit;

    wake_state_t  wake_q, wake_n;
    logic         wu_q, wu_n;
    logic [31:0]  sleep_cnt;

    flush_state_t flush_q, flush_n;

    // Packed [i][j] flattens to index 2*i + j.
    assign evt_flat = evt;
    assign evt_hit  = |(pending_q & mask_q);

    // A set in the same cycle as a clear wins, so no event is lost.
    always_comb begin
        clr_bits  = clr_valid ? clr_mask : '0;
        pending_n = (pending_q & ~clr_bits) | evt_flat;
    end

    always_comb begin
        irq_n = '0;
        irq_n[EVT_IRQ_BASE +: N_EVT] = pending_q & mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= '0;
        end else begin
            pending_q <= pending_n;
            irq_q     <= irq_n;
            if (cfg_we) begin
                mask_q <= cfg_mask;
            end
        end
    end

    always_comb begin
        wake_n = wake_q;
        wu_n   = 1'b0;
        case (wake_q)
            IDLE: begin
                if (core_sleep) begin
                    wake_n = SLEEP;
                end
            end
            SLEEP: begin
                if (evt_hit) begin
                    wake_n = WAKE;
                    wu_n   = 1'b1;
                end else if (!core_sleep) begin
                    wake_n = IDLE;
                end
            end
            WAKE: begin
                if (!core_sleep) begin
                    wake_n = IDLE;
                end
            end
            default: wake_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wake_q    <= IDLE;
            wu_q      <= 1'b0;
            sleep_cnt <= '0;
        end else begin
            wake_q <= wake_n;
            wu_q   <= wu_n;
            if (wake_q == SLEEP && sleep_cnt != 32'hFFFF_FFFF) begin
                sleep_cnt <= sleep_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        flush_n = flush_q;
        case (flush_q)
            F_IDLE: begin
                if (fencei_flush_req) begin
                    flush_n = F_WAIT;
                end
            end
            F_WAIT: begin
                if (!fencei_flush_req) begin
                    flush_n = F_IDLE;
                end else if (!busy) begin
                    flush_n = F_ACK;
                end
            end
            F_ACK: begin
                if (!fencei_flush_req) begin
                    flush_n = F_IDLE;
                end
            end
            default: flush_n = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q <= F_IDLE;
        end else begin
            flush_q <= flush_n;
        end
    end

    assign pending          = pending_q;
    assign irq              = irq_q;
    assign wu_wfe           = wu_q;
    assign sleep_cycles     = sleep_cnt;
    assign fencei_flush_ack = (flush_q == F_ACK);

endmodule

// File: tb/tb_redmule_tile_evt_ctrl.sv
// Bench for redmule_tile_evt_ctrl: a behavioural model pushes expected outputs per
// cycle into a queue; they are popped and compared after the DUT clock edge.
module tb_redmule_tile_evt_ctrl;

    logic             clk;
    logic             rst;
    logic [0:0][1:0]  evt;
    logic             busy;
    logic             core_sleep;
    logic             fencei_flush_req;
    logic             fencei_flush_ack;
    logic             cfg_we;
    logic [1:0]       cfg_mask;
    logic             clr_valid;
    logic [1:0]       clr_mask;
    logic [31:0]      irq;
    logic             wu_wfe;
    logic [1:0]       pending;
    logic [31:0]      sleep_cycles;

    redmule_tile_evt_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .evt              (evt),
        .busy             (busy),
        .core_sleep       (core_sleep),
        .fencei_flush_req (fencei_flush_req),
        .fencei_flush_ack (fencei_flush_ack),
        .cfg_we           (cfg_we),
        .cfg_mask         (cfg_mask),
        .clr_valid        (clr_valid),
        .clr_mask         (clr_mask),
        .irq              (irq),
        .wu_wfe           (wu_wfe),
        .pending          (pending),
        .sleep_cycles     (sleep_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pend;
        logic [31:0] irq;
        logic        wu;
        logic        ack;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // model state: wake 0=idle 1=sleep 2=wake; flush 0=idle 1=wait 2=ack
    logic [1:0]  m_pend = '0;
    logic [1:0]  m_mask = '0;
    logic [31:0] m_irq  = '0;
    logic        m_wu   = 1'b0;
    logic [31:0] m_sc   = '0;
    int          m_ws   = 0;
    int          m_fs   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cycle();
        exp_t        e;
        logic [1:0]  pn;
        logic [1:0]  mn;
        logic [31:0] in;
        logic        wn;
        logic [31:0] sn;
        int          wsn;
        int          fsn;
        logic        hit;
        hit = |(m_pend & m_mask);
        pn  = (m_pend & ~(clr_valid ? clr_mask : 2'b00)) | evt[0];
        mn  = cfg_we ? cfg_mask : m_mask;
        in  = '0;
        in[16] = m_pend[0] & m_mask[0];
        in[17] = m_pend[1] & m_mask[1];
        wn  = 1'b0;
        wsn = m_ws;
        if (m_ws == 0 && core_sleep) wsn = 1;
        else if (m_ws == 1 && hit) begin wsn = 2; wn = 1'b1; end
        else if (m_ws == 1 && !core_sleep) wsn = 0;
        else if (m_ws == 2 && !core_sleep) wsn = 0;
        sn = (m_ws == 1 && m_sc != 32'hFFFF_FFFF) ? m_sc + 1 : m_sc;
        fsn = m_fs;
        if (m_fs == 0 && fencei_flush_req) fsn = 1;
        else if (m_fs == 1 && !fencei_flush_req) fsn = 0;
        else if (m_fs == 1 && !busy) fsn = 2;
        else if (m_fs == 2 && !fencei_flush_req) fsn = 0;
        if (rst) begin
            pn = '0; mn = '0; in = '0; wn = 1'b0; sn = '0; wsn = 0; fsn = 0;
        end
        e.pend = pn; e.irq = in; e.wu = wn; e.ack = (fsn == 2); e.sc = sn;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pending", {30'd0, pending}, {30'd0, e.pend});
        check("irq", irq, e.irq);
        check("wu_wfe", {31'd0, wu_wfe}, {31'd0, e.wu});
        check("flush_ack", {31'd0, fencei_flush_ack}, {31'd0, e.ack});
        check("sleep_cycles", sleep_cycles, e.sc);
        m_pend = pn; m_mask = mn; m_irq = in; m_wu = wn; m_sc = sn; m_ws = wsn; m_fs = fsn;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_evt(input logic [1:0] v);
        evt[0] = v;
        cycle();
        evt[0] = 2'b00;
    endtask

    task automatic clear(input logic [1:0] v);
        clr_valid = 1'b1;
        clr_mask  = v;
        cycle();
        clr_valid = 1'b0;
        clr_mask  = 2'b00;
    endtask

    task automatic set_mask(input logic [1:0] v);
        cfg_we   = 1'b1;
        cfg_mask = v;
        cycle();
        cfg_we   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wu_cnt;
        int          ack_seen;
        logic [31:0] s0;

        rst = 1'b1; evt = '0; busy = 1'b0; core_sleep = 1'b0;
        fencei_flush_req = 1'b0; cfg_we = 1'b0; cfg_mask = '0;
        clr_valid = 1'b0; clr_mask = '0;
        run(2);
        check("rst_pending", {30'd0, pending}, 32'd0);
        check("rst_irq", irq, 32'd0);
        rst = 1'b0;
        run(2);

        // mask 01, event bit 0: pending at t+1, irq[16] at t+2
        set_mask(2'b01);
        pulse_evt(2'b01);
        check("basic_pend", {30'd0, pending}, 32'd1);
        check("basic_irq16_early", {31'd0, irq[16]}, 32'd0);
        cycle();
        check("basic_irq16", {31'd0, irq[16]}, 32'd1);
        check("basic_irq17", {31'd0, irq[17]}, 32'd0);

        // unmasked bit 1 sets pending but no irq
        pulse_evt(2'b10);
        run(2);
        check("unmasked_pend", {30'd0, pending}, 32'd3);
        check("unmasked_irq17", {31'd0, irq[17]}, 32'd0);
        clear(2'b10);

        // clear collides with set: set wins; then clear alone
        clr_valid = 1'b1; clr_mask = 2'b01; evt[0] = 2'b01;
        cycle();
        clr_valid = 1'b0; clr_mask = 2'b00; evt[0] = 2'b00;
        check("clr_collide", {30'd0, pending}, 32'd1);
        clear(2'b01);
        check("clr_alone", {30'd0, pending}, 32'd0);
        check("clr_irq_lag", {31'd0, irq[16]}, 32'd1);
        cycle();
        check("clr_irq_low", {31'd0, irq[16]}, 32'd0);
        run(2);

        // sleep, event wakes exactly once, WAKE holds while core_sleep=1
        s0 = sleep_cycles;
        wu_cnt = 0;
        core_sleep = 1'b1;
        run(3);
        pulse_evt(2'b01);
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (wu_wfe) wu_cnt++;
        end
        check("wake_once", wu_cnt, 1);
        core_sleep = 1'b0;
        run(2);
        check("sleep_delta", sleep_cycles - s0, 32'd4);

        // pending already set on SLEEP entry: no lost wake-up
        wu_cnt = 0;
        core_sleep = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (wu_wfe) wu_cnt++;
        end
        check("early_pend_wake", wu_cnt, 1);
        core_sleep = 1'b0;
        cycle();
        clear(2'b01);
        run(2);

        // sleep abandoned without an event
        wu_cnt = 0;
        core_sleep = 1'b1;
        run(3);
        core_sleep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (wu_wfe) wu_cnt++;
        end
        check("no_evt_no_wake", wu_cnt, 0);

        // flush while core sleeps with everything masked
        set_mask(2'b00);
        core_sleep = 1'b1;
        busy = 1'b1; fencei_flush_req = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (fencei_flush_ack) ack_seen++;
        end
        check("ack_while_busy", ack_seen, 0);
        busy = 1'b0;
        cycle();
        check("ack_rise", {31'd0, fencei_flush_ack}, 32'd1);
        run(3);
        check("ack_hold", {31'd0, fencei_flush_ack}, 32'd1);
        fencei_flush_req = 1'b0;
        cycle();
        check("ack_fall", {31'd0, fencei_flush_ack}, 32'd0);

        // request withdrawn while waiting: no ack
        busy = 1'b1; fencei_flush_req = 1'b1;
        run(3);
        fencei_flush_req = 1'b0;
        cycle();
        busy = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (fencei_flush_ack) ack_seen++;
        end
        check("abort_no_ack", ack_seen, 0);

        // reset in SLEEP with pending=11 and flush in F_ACK
        pulse_evt(2'b11);
        fencei_flush_req = 1'b1;
        run(2);
        rst = 1'b1; evt[0] = 2'b11; cfg_we = 1'b1; cfg_mask = 2'b11;
        clr_valid = 1'b1; clr_mask = 2'b11;
        cycle();
        check("rstmid_pending", {30'd0, pending}, 32'd0);
        check("rstmid_irq", irq, 32'd0);
        check("rstmid_wu", {31'd0, wu_wfe}, 32'd0);
        check("rstmid_ack", {31'd0, fencei_flush_ack}, 32'd0);
        check("rstmid_sc", sleep_cycles, 32'd0);
        rst = 1'b0; evt[0] = 2'b00; cfg_we = 1'b0; cfg_mask = 2'b00;
        clr_valid = 1'b0; clr_mask = 2'b00;
        core_sleep = 1'b0; fencei_flush_req = 1'b0;
        run(2);
        check("post_rst_pend", {30'd0, pending}, 32'd0);
        pulse_evt(2'b10);
        cycle();
        check("post_rst_evt", {30'd0, pending}, 32'd2);
        check("post_rst_irq", irq, 32'd0);
        clear(2'b10);

        // saturation of sleep counter
        core_sleep = 1'b1;
        run(2);
        force dut.sleep_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.sleep_cnt;
        m_sc = 32'hFFFF_FFFE;
        run(4);
        check("sleep_sat", sleep_cycles, 32'hFFFF_FFFF);
        core_sleep = 1'b0;
        run(2);
        check("sleep_sat_hold", sleep_cycles, 32'hFFFF_FFFF);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
